// File: rtl/fsm_datapath_if.sv
// Control-word and observation bundle between the FSM control unit and the execution datapath.
// The master drives the control word; the slave executes it and reports its results.
interface fsm_datapath_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned IMM_WIDTH     = 16
);
  logic                     rf1;
  logic                     rf2;
  logic                     en1;
  logic                     s1;
  logic                     s2;
  logic                     alu1;
  logic                     alu2;
  logic                     en2;
  logic                     rm;
  logic                     wm;
  logic                     en3;
  logic                     s3;
  logic                     wf1;
  logic [RF_ADDR_WIDTH-1:0] rs1;
  logic [RF_ADDR_WIDTH-1:0] rs2;
  logic [RF_ADDR_WIDTH-1:0] rd;
  logic [IMM_WIDTH-1:0]     imm;
  logic [DATA_WIDTH-1:0]    alu_out;
  logic                     wb_en;
  logic [RF_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;

  modport master (
    output rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1,
    output rs1, rs2, rd, imm,
    input  alu_out, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1,
    input  rs1, rs2, rd, imm,
    output alu_out, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/fsm_datapath.sv
// Three-stage execution datapath: operand fetch, ALU, memory/write-back.
// Each stage advances only on its own enable from the control word.
module fsm_datapath #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RF_ADDR_WIDTH   = 5,
  parameter int unsigned IMM_WIDTH       = 16,
  parameter int unsigned DMEM_ADDR_WIDTH = 6
) (
  input  logic          clk,
  input  logic          rst,
  fsm_datapath_if.slave bus
);
  localparam int unsigned RF_DEPTH   = 1 << RF_ADDR_WIDTH;
  localparam int unsigned DMEM_DEPTH = 1 << DMEM_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]      rf   [RF_DEPTH];
  logic [DATA_WIDTH-1:0]      dmem [DMEM_DEPTH];

  logic [DATA_WIDTH-1:0]      a_q;
  logic [DATA_WIDTH-1:0]      b_q;
  logic [DATA_WIDTH-1:0]      imm_q;
  logic [RF_ADDR_WIDTH-1:0]   rd1_q;
  logic [DATA_WIDTH-1:0]      alu_q;
  logic [DATA_WIDTH-1:0]      b2_q;
  logic [RF_ADDR_WIDTH-1:0]   rd2_q;
  logic                       wb_en_q;
  logic [RF_ADDR_WIDTH-1:0]   wb_addr_q;
  logic [DATA_WIDTH-1:0]      wb_data_q;

  logic [DMEM_ADDR_WIDTH-1:0] maddr_c;
  logic [DATA_WIDTH-1:0]      mem_rd_c;
  logic [DATA_WIDTH-1:0]      wb_val_c;
  logic                       rf_we_c;
  logic [DATA_WIDTH-1:0]      rd_a_c;
  logic [DATA_WIDTH-1:0]      rd_b_c;
  logic [DATA_WIDTH-1:0]      imm_x_c;
  logic [DATA_WIDTH-1:0]      op1_c;
  logic [DATA_WIDTH-1:0]      op2_c;
  logic [DATA_WIDTH-1:0]      alu_c;

  // Stage-3 memory read/write-back value, stage-1 reads with write-first bypass, ALU
  always_comb begin
    maddr_c  = alu_q[DMEM_ADDR_WIDTH-1:0];
    mem_rd_c = '0;
    if (bus.en3 && bus.rm) mem_rd_c = dmem[maddr_c];
    wb_val_c = bus.s3 ? mem_rd_c : alu_q;
    rf_we_c  = bus.en3 && bus.wf1 && (rd2_q != '0);

    rd_a_c = '0;
    if (bus.rf1) rd_a_c = (rf_we_c && (rd2_q == bus.rs1)) ? wb_val_c : rf[bus.rs1];
    rd_b_c = '0;
    if (bus.rf2) rd_b_c = (rf_we_c && (rd2_q == bus.rs2)) ? wb_val_c : rf[bus.rs2];
    imm_x_c = DATA_WIDTH'($signed(bus.imm));

    op1_c = bus.s1 ? imm_q : a_q;
    op2_c = bus.s2 ? imm_q : b_q;
    case ({bus.alu1, bus.alu2})
      2'b00:   alu_c = op1_c + op2_c;
      2'b01:   alu_c = op1_c - op2_c;
      2'b10:   alu_c = op1_c & op2_c;
      default: alu_c = op1_c | op2_c;
    endcase
  end

  // Stage 1 and stage 2 pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      rd1_q <= '0;
      alu_q <= '0;
      b2_q  <= '0;
      rd2_q <= '0;
    end else begin
      if (bus.en1) begin
        a_q   <= rd_a_c;
        b_q   <= rd_b_c;
        imm_q <= imm_x_c;
        rd1_q <= bus.rd;
      end
      if (bus.en2) begin
        alu_q <= alu_c;
        b2_q  <= b_q;
        rd2_q <= rd1_q;
      end
    end
  end

  // Register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (rf_we_c) begin
      rf[rd2_q] <= wb_val_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (bus.en3 && bus.wm) begin
      dmem[maddr_c] <= b2_q;
    end
  end

  // Observation of the register-file write committed on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= rf_we_c;
      if (rf_we_c) begin
        wb_addr_q <= rd2_q;
        wb_data_q <= wb_val_c;
      end
    end
  end

  assign bus.alu_out = alu_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_fsm_datapath.sv
// Bench for fsm_datapath: directed and random instructions against an architectural model,
// write-backs checked by an independent monitor through an expectation queue.
module tb_fsm_datapath;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 16;
  localparam int unsigned MW = 6;

  logic clk;
  logic rst;

  fsm_datapath_if #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .IMM_WIDTH(IW)) bus ();

  fsm_datapath #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .IMM_WIDTH(IW), .DMEM_ADDR_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  typedef struct {
    logic          rf1, rf2, s1, s2, s3, rm, wm, wf1, en3;
    logic [1:0]    op;
    logic [AW-1:0] rs1, rs2, rd;
    logic [IW-1:0] imm;
  } ins_t;

  wb_t           exp_q[$];
  logic [DW-1:0] rf_m   [32];
  logic [DW-1:0] dmem_m [64];
  int            total = 0;
  int            bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    {bus.rf1, bus.rf2, bus.en1, bus.s1, bus.s2, bus.alu1, bus.alu2} = '0;
    {bus.en2, bus.rm, bus.wm, bus.en3, bus.s3, bus.wf1} = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.rd  = '0;
    bus.imm = '0;
  endtask

  function automatic logic [DW-1:0] sext(input logic [IW-1:0] i);
    return {{(DW-IW){i[IW-1]}}, i};
  endfunction

  function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic ins_t mk(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                              input logic [AW-1:0] rd, input logic [IW-1:0] imm, input logic s1,
                              input logic s2, input logic s3, input logic rm, input logic wm, input logic wf1);
    ins_t t;
    t.rf1 = 1'b1; t.rf2 = 1'b1; t.en3 = 1'b1;
    t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.imm = imm;
    t.s1 = s1; t.s2 = s2; t.s3 = s3; t.rm = rm; t.wm = wm; t.wf1 = wf1;
    return t;
  endfunction

  task automatic model_reset();
    foreach (rf_m[i]) rf_m[i] = '0;
    foreach (dmem_m[i]) dmem_m[i] = '0;
  endtask

  // One complete instruction: three successive control words, model predicts its effect
  task automatic run(input ins_t t, input string tag);
    logic [DW-1:0] a, b, alu, mem, wbv;
    logic [MW-1:0] addr;
    a    = t.rf1 ? rf_m[t.rs1] : '0;
    b    = t.rf2 ? rf_m[t.rs2] : '0;
    alu  = alu_f(t.op, t.s1 ? sext(t.imm) : a, t.s2 ? sext(t.imm) : b);
    addr = alu[MW-1:0];

    idle();
    bus.en1 = 1'b1; bus.rf1 = t.rf1; bus.rf2 = t.rf2;
    bus.rs1 = t.rs1; bus.rs2 = t.rs2; bus.rd = t.rd; bus.imm = t.imm;
    step();
    idle();
    bus.en2 = 1'b1; bus.s1 = t.s1; bus.s2 = t.s2; {bus.alu1, bus.alu2} = t.op;
    step();
    chk({tag, "_alu"}, bus.alu_out, alu);

    if (t.en3) begin
      mem = t.rm ? dmem_m[addr] : '0;
      if (t.wm) dmem_m[addr] = b;
      wbv = t.s3 ? mem : alu;
      if (t.wf1 && t.rd != '0) begin
        rf_m[t.rd] = wbv;
        exp_q.push_back('{addr: t.rd, data: wbv});
      end
    end
    idle();
    bus.en3 = t.en3; bus.rm = t.rm; bus.wm = t.wm; bus.s3 = t.s3; bus.wf1 = t.wf1;
    step();
    idle();
  endtask

  // Register contents become visible on the write-back port through r31
  task automatic readback(input logic [AW-1:0] r);
    run(mk(2'd3, r, 5'd0, 5'd31, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "readback");
  endtask

  task automatic addi(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic [IW-1:0] imm);
    run(mk(2'd0, rs, 5'd0, rd, imm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "addi");
  endtask

  // Monitor: every write-back the DUT reports must match the oldest expectation
  initial begin : monitor
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got addr %0d data %h want no write", bus.wb_addr, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", DW'(bus.wb_addr), DW'(e.addr));
          chk("wb_data", bus.wb_data, e.data);
        end
      end
    end
  end

  initial begin : stim
    ins_t t;
    rst = 1'b1;
    idle();
    model_reset();
    step();
    step();
    chk("rst_alu_out", bus.alu_out, '0);
    chk("rst_wb_en", DW'(bus.wb_en), '0);
    chk("rst_wb_addr", DW'(bus.wb_addr), '0);
    chk("rst_wb_data", bus.wb_data, '0);
    rst = 1'b0;
    step();

    // Asynchronous reset in the middle of stage 2
    addi(5'd3, 5'd0, 16'd7);
    bus.en1 = 1'b1; bus.rf1 = 1'b1; bus.rs1 = 5'd3; bus.imm = 16'd1; bus.rd = 5'd9;
    step();
    idle();
    bus.en2 = 1'b1; bus.s2 = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_alu_out", bus.alu_out, '0);
    chk("async_wb_en", DW'(bus.wb_en), '0);
    chk("async_wb_data", bus.wb_data, '0);
    model_reset();
    step();
    idle();
    rst = 1'b0;
    step();
    readback(5'd3);

    // ADDI with negative immediate
    addi(5'd1, 5'd0, 16'd5);
    addi(5'd2, 5'd1, 16'hFFFF);

    // SUB / AND / OR
    addi(5'd1, 5'd0, 16'h0F0F);
    addi(5'd2, 5'd0, 16'h00FF);
    for (int op = 1; op < 4; op++)
      run(mk(2'(op), 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "regop");

    // Store at wrapped address 0x41 -> word 1, load back, then read-during-write
    addi(5'd7, 5'd0, 16'h5BCD);
    addi(5'd7, 5'd7, 16'h5000);
    run(mk(2'd0, 5'd0, 5'd7, 5'd0, 16'h0041, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), "store");
    run(mk(2'd0, 5'd0, 5'd0, 5'd4, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), "load");
    run(mk(2'd0, 5'd0, 5'd1, 5'd8, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), "rmw");
    run(mk(2'd0, 5'd0, 5'd0, 5'd8, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), "reload");

    // Write to R0 dropped; write with stage 3 disabled ignored
    addi(5'd0, 5'd0, 16'h0055);
    readback(5'd0);
    t = mk(2'd0, 5'd0, 5'd0, 5'd2, 16'h0099, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    t.en3 = 1'b0;
    run(t, "noen3");
    readback(5'd2);

    // Bypass: stage-3 write of r5 overlaps the stage-1 read of r5
    idle();
    bus.en1 = 1'b1; bus.rf1 = 1'b1; bus.rs1 = 5'd0; bus.imm = 16'd9; bus.rd = 5'd5;
    step();
    idle();
    bus.en2 = 1'b1; bus.s2 = 1'b1;
    step();
    chk("bypass_alu1", bus.alu_out, 32'd9);
    rf_m[5] = 32'd9;
    exp_q.push_back('{addr: 5'd5, data: 32'd9});
    idle();
    bus.en3 = 1'b1; bus.wf1 = 1'b1;
    bus.en1 = 1'b1; bus.rf1 = 1'b1; bus.rs1 = 5'd5; bus.imm = 16'd1; bus.rd = 5'd6;
    step();
    idle();
    bus.en2 = 1'b1; bus.s2 = 1'b1;
    step();
    chk("bypass_alu2", bus.alu_out, 32'd10);
    rf_m[6] = 32'd10;
    exp_q.push_back('{addr: 5'd6, data: 32'd10});
    idle();
    bus.en3 = 1'b1; bus.wf1 = 1'b1;
    step();
    idle();

    // Random instructions
    for (int n = 0; n < 80; n++) begin
      t.op  = 2'($urandom_range(0, 3));
      t.rs1 = 5'($urandom_range(0, 31));
      t.rs2 = 5'($urandom_range(0, 31));
      t.rd  = 5'($urandom_range(0, 31));
      t.imm = 16'($urandom);
      {t.rf1, t.rf2, t.s1, t.s2, t.s3, t.rm, t.wm, t.wf1} = 8'($urandom);
      t.en3 = ($urandom_range(0, 4) != 0);
      run(t, "rand");
    end

    step();
    step();
    step();
    chk("pending_wb", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
